// File: rtl/soc_arb_pkg.sv
// Shared types and constants for the SoC bus arbiter.
// Also holds the index-width helper used by the round-robin picker.
package soc_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 256;
    localparam int TO_CNT_W        = 16;
    localparam int EVT_CNT_W       = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_rr_picker.sv
// Combinational round-robin picker: one-hot pick of the first
// requester found searching upward from (last_grant+1) mod N.
module soc_rr_picker
    import soc_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int LG_W = idx_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [LG_W-1:0] last_grant,
    output logic [N-1:0]    pick
);

    // Walk distances farthest-first so the nearest requester overwrites.
    always_comb begin
        pick = '0;
        for (int i = N; i >= 1; i--) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && (((int'(last_grant) + i) % N) == j)) begin
                    pick    = '0;
                    pick[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Round-robin arbiter sharing one SoC bus master port among
// NUM_MASTERS requesters, with a per-transfer timeout.
module soc_bus_arbiter
    import soc_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [4*NUM_MASTERS-1:0]  m_be_i,
    input  logic [32*NUM_MASTERS-1:0] m_addr_i,
    input  logic [32*NUM_MASTERS-1:0] m_wdata_i,
    output logic [31:0]               m_rdata_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_error_o,
    output logic                      s_req_o,
    output logic                      s_we_o,
    output logic [3:0]                s_be_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    input  logic [31:0]               s_rdata_i,
    input  logic                      s_ack_i,
    input  logic                      s_error_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic [7:0]                timeout_cnt_o
);

    localparam int LG_W = idx_w(NUM_MASTERS);

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [LG_W-1:0]        r_last;
    logic [TO_CNT_W-1:0]    r_tmo;
    logic [EVT_CNT_W-1:0]   r_tocnt;

    logic [NUM_MASTERS-1:0] w_pick;
    logic [LG_W-1:0]        w_pick_idx;
    logic                   w_busy;
    logic                   w_ack;
    logic                   w_err;
    logic                   w_tmo_hit;

    soc_rr_picker #(
        .N    (NUM_MASTERS),
        .LG_W (LG_W)
    ) u_picker (
        .req        (m_req_i),
        .last_grant (r_last),
        .pick       (w_pick)
    );

    // Encode the one-hot pick into an index for last_grant.
    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_pick[k]) w_pick_idx = LG_W'(k);
        end
    end

    // Ack beats slave error, and either beats the timeout.
    always_comb begin
        w_busy    = (r_state == BUSY) && !rst;
        w_ack     = w_busy && s_ack_i;
        w_err     = w_busy && !s_ack_i && s_error_i;
        w_tmo_hit = w_busy && !s_ack_i && !s_error_i &&
                    (r_tmo == TO_CNT_W'(TIMEOUT - 1));
    end

    // All arbiter state: FSM, grant, last grant and both counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LG_W'(NUM_MASTERS - 1);
            r_tmo   <= '0;
            r_tocnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tmo <= '0;
                    if (|m_req_i) begin
                        r_state <= BUSY;
                        r_grant <= w_pick;
                        r_last  <= w_pick_idx;
                    end
                end
                BUSY: begin
                    if (w_ack || w_err || w_tmo_hit) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        if (w_tmo_hit && (r_tocnt != '1)) begin
                            r_tocnt <= r_tocnt + 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Downstream mux of the granted master; zero when idle or in reset.
    always_comb begin
        s_req_o   = w_busy;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (w_busy) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (r_grant[k]) begin
                    s_we_o    = m_we_i[k];
                    s_be_o    = m_be_i[4*k +: 4];
                    s_addr_o  = m_addr_i[32*k +: 32];
                    s_wdata_o = m_wdata_i[32*k +: 32];
                end
            end
        end
    end

    // Upstream responses steered only to the current owner.
    always_comb begin
        m_ack_o       = w_ack ? r_grant : '0;
        m_error_o     = (w_err || w_tmo_hit) ? r_grant : '0;
        m_rdata_o     = w_ack ? s_rdata_i : '0;
        grant_o       = rst ? '0 : r_grant;
        timeout_cnt_o = rst ? '0 : r_tocnt;
    end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Self-checking bench for soc_bus_arbiter (2 masters, TIMEOUT=8):
// directed scenarios with literal expectations plus a random phase.
module tb_soc_bus_arbiter;

    localparam int N = 2;
    localparam int T = 8;

    logic        clk;
    logic        rst;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [7:0]  m_be;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [31:0] m_rdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic        s_req;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_ack;
    logic        s_err;
    logic [1:0]  grant;
    logic [7:0]  tocnt_o;

    int checks   = 0;
    int failures = 0;

    soc_bus_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT     (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m_req_i       (m_req),
        .m_we_i        (m_we),
        .m_be_i        (m_be),
        .m_addr_i      (m_addr),
        .m_wdata_i     (m_wdata),
        .m_rdata_o     (m_rdata),
        .m_ack_o       (m_ack),
        .m_error_o     (m_err),
        .s_req_o       (s_req),
        .s_we_o        (s_we),
        .s_be_o        (s_be),
        .s_addr_o      (s_addr),
        .s_wdata_o     (s_wdata),
        .s_rdata_i     (s_rdata),
        .s_ack_i       (s_ack),
        .s_error_i     (s_err),
        .grant_o       (grant),
        .timeout_cnt_o (tocnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Transaction-level model: owner (-1 = nobody), last owner,
    // cycles spent waiting on the slave, and the timeout tally.
    int       own   = -1;
    int       last  = N - 1;
    int       age   = 0;
    int       tocnt = 0;
    int       cand;
    bit [1:0] done_mask = '0;
    logic [1:0]  eg, ea, ee;
    logic [31:0] er;
    bit          tmo;

    always @(negedge clk) begin
        eg  = '0;
        ea  = '0;
        ee  = '0;
        er  = '0;
        tmo = 1'b0;
        if (!rst && own >= 0) begin
            eg  = 2'(1 << own);
            tmo = !s_ack && !s_err && (age == T - 1);
            if (s_ack) begin
                ea = eg;
                er = s_rdata;
            end else if (s_err || tmo) begin
                ee = eg;
            end
        end
        check("grant", grant, eg);
        check("s_req", s_req, (!rst && own >= 0));
        check("m_ack", m_ack, ea);
        check("m_error", m_err, ee);
        check("m_rdata", m_rdata, er);
        check("tocnt", tocnt_o, rst ? 0 : tocnt);
        if (eg != 0) begin
            check("s_we", s_we, m_we[own]);
            check("s_be", s_be, m_be[4*own +: 4]);
            check("s_addr", s_addr, m_addr[32*own +: 32]);
            check("s_wdata", s_wdata, m_wdata[32*own +: 32]);
        end
        done_mask = ea | ee;
        if (rst) begin
            own   = -1;
            last  = N - 1;
            age   = 0;
            tocnt = 0;
        end else if (own < 0) begin
            for (int d = 1; d <= N; d++) begin
                cand = (last + d) % N;
                if (own < 0 && m_req[cand]) own = cand;
            end
            if (own >= 0) begin
                last = own;
                age  = 0;
            end
        end else if (ea != 0 || ee != 0) begin
            if (tmo) tocnt = (tocnt < 255) ? tocnt + 1 : 255;
            own = -1;
        end else begin
            age++;
        end
    end

    logic [1:0] exp_g [6];
    int         r;

    initial begin
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        step();
        step();
        mid();
        check("rst_grant", grant, 2'b00);
        check("rst_sreq", s_req, 1'b0);
        check("rst_tocnt", tocnt_o, 8'd0);

        // Single master, ack three cycles after first BUSY cycle.
        step();
        rst     = 1'b0;
        m_req   = 2'b01;
        m_we    = 2'b01;
        m_be    = 8'h0F;
        m_addr  = 64'h0000_0000_0000_0100;
        m_wdata = 64'h0000_0000_1234_5678;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) begin
                s_ack   = 1'b1;
                s_rdata = 32'hCAFE_0001;
            end
            mid();
            check("t1_sreq", s_req, 1'b1);
            check("t1_addr", s_addr, 32'h100);
            check("t1_ack", m_ack, (c == 4) ? 2'b01 : 2'b00);
            if (c == 4) check("t1_rdata", m_rdata, 32'hCAFE_0001);
        end
        step();
        s_ack = 1'b0;
        m_req = 2'b00;
        mid();
        check("t1_grant_clr", grant, 2'b00);
        check("t1_sreq_clr", s_req, 1'b0);

        // Contention after reset: 01, idle, 10, idle, 01, idle.
        step();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        m_req = 2'b11;
        s_ack = 1'b1;
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 5) begin
                m_req = 2'b00;
                s_ack = 1'b0;
            end
            mid();
            check("t2_grant", grant, exp_g[i]);
            if (i == 2) check("t2_ack1", m_ack, 2'b10);
        end

        // Timeout with silent slave, then saturation.
        step();
        m_req = 2'b10;
        for (int c = 1; c <= 8; c++) begin
            step();
            mid();
            check("t3_err", m_err, (c == 8) ? 2'b10 : 2'b00);
            check("t3_tocnt", tocnt_o, 8'd0);
        end
        step();
        m_req = 2'b01;
        mid();
        check("t3_tocnt1", tocnt_o, 8'd1);
        check("t3_grant", grant, 2'b00);
        repeat (299 * 9 - 1) step();
        step();
        m_req = 2'b00;
        mid();
        check("t3_sat", tocnt_o, 8'd255);

        // Reset clears the tally; outputs forced low during reset.
        step();
        rst = 1'b1;
        mid();
        check("t4_rst_tocnt", tocnt_o, 8'd0);
        step();
        rst   = 1'b0;
        m_req = 2'b01;
        step();
        s_ack   = 1'b1;
        s_err   = 1'b1;
        s_rdata = 32'hA5A5_0046;
        mid();
        check("t4_ack", m_ack, 2'b01);
        check("t4_err", m_err, 2'b00);
        check("t4_rdata", m_rdata, 32'hA5A5_0046);
        step();
        s_ack = 1'b0;
        s_err = 1'b0;
        m_req = 2'b00;
        mid();
        check("t4_grant", grant, 2'b00);

        // Ack in the timeout cycle.
        step();
        m_req = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) begin
                s_ack   = 1'b1;
                s_rdata = 32'h0000_0047;
            end
            mid();
            if (c == 8) begin
                check("t5_ack", m_ack, 2'b01);
                check("t5_err", m_err, 2'b00);
            end
        end
        step();
        s_ack = 1'b0;
        m_req = 2'b00;
        mid();
        check("t5_tocnt", tocnt_o, 8'd0);

        // Reset in the second BUSY cycle.
        step();
        m_req = 2'b01;
        step();
        mid();
        check("t6_grant", grant, 2'b01);
        step();
        rst = 1'b1;
        mid();
        check("t6_rst_sreq", s_req, 1'b0);
        check("t6_rst_ack", m_ack | m_err, 2'b00);
        step();
        rst   = 1'b0;
        m_req = 2'b11;
        mid();
        check("t6_sreq", s_req, 1'b0);
        check("t6_grant0", grant, 2'b00);
        check("t6_noresp", m_ack | m_err, 2'b00);
        step();
        s_ack = 1'b1;
        mid();
        check("t6_regrant", grant, 2'b01);
        step();
        s_ack = 1'b0;
        m_req = 2'b00;

        // Request dropped mid-transfer: grant is held.
        step();
        m_req = 2'b10;
        step();
        step();
        m_req = 2'b00;
        mid();
        check("t7_hold", grant, 2'b10);
        step();
        s_ack = 1'b1;
        mid();
        check("t7_ack", m_ack, 2'b10);
        step();
        s_ack = 1'b0;

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                if (done_mask[k]) begin
                    m_req[k] = 1'b0;
                end else if (!m_req[k] && $urandom_range(0, 2) == 0) begin
                    m_req[k]            = 1'b1;
                    m_we[k]             = 1'($urandom);
                    m_be[4*k +: 4]      = 4'($urandom);
                    m_addr[32*k +: 32]  = $urandom;
                    m_wdata[32*k +: 32] = $urandom;
                end
            end
            r       = int'($urandom_range(0, 19));
            s_ack   = (r < 3) || (r == 4);
            s_err   = (r == 3) || (r == 4);
            s_rdata = $urandom;
        end
        step();
        rst   = 1'b0;
        m_req = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
        step();
        mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_bus_arbiter.md
SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, meaning the number of bus masters sharing one downstream port (range 2..4).
REQ-002 SHALL have parameter TIMEOUT, default 256, meaning the maximum number of cycles a downstream transfer may wait for ack or error (range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port m_req_i, input, NUM_MASTERS bits: per-master request.
REQ-006 SHALL have port m_we_i, input, NUM_MASTERS bits: per-master write enable.
REQ-007 SHALL have port m_be_i, input, 4*NUM_MASTERS bits: per-master byte enables; master k occupies slice [4k+3:4k].
REQ-008 SHALL have port m_addr_i, input, 32*NUM_MASTERS bits: per-master address, slice [32k+31:32k].
REQ-009 SHALL have port m_wdata_i, input, 32*NUM_MASTERS bits: per-master write data.
REQ-010 SHALL have port m_rdata_o, output, 32 bits: read data, shared by all masters and valid only with that master's ack.
REQ-011 SHALL have port m_ack_o, output, NUM_MASTERS bits: per-master completion pulse.
REQ-012 SHALL have port m_error_o, output, NUM_MASTERS bits: per-master error pulse, from the slave error or a timeout.
REQ-013 SHALL have downstream ports s_req_o, s_we_o, s_be_o[3:0], s_addr_o[31:0] and s_wdata_o[31:0] as outputs, and s_rdata_i[31:0], s_ack_i and s_error_i as inputs, all connecting to the SoC bus master port.
REQ-014 SHALL have port grant_o, output, NUM_MASTERS bits: one-hot current owner, all zero when idle.
REQ-015 SHALL have port timeout_cnt_o, output, 8 bits: saturating count of timeouts.

Function
REQ-016 SHALL implement states IDLE and BUSY.
REQ-017 Request protocol: a master SHALL hold req, we, be, addr and wdata stable until it receives its ack or error pulse.
REQ-018 In IDLE with any m_req_i bit set, the block SHALL select one master round-robin, searching from (last_grant+1) mod NUM_MASTERS.
REQ-019 On that selection, the block SHALL register grant and last_grant and go to BUSY at the next edge.
REQ-020 In IDLE, s_req_o SHALL be 0.
REQ-021 In BUSY, s_req_o SHALL be 1 and the s_* fields SHALL be a combinational mux of the granted master's inputs.
REQ-022 Latency: m_req_i sampled high at edge N gives s_req_o=1 in cycle N+1, minimum.
REQ-023 In BUSY with s_ack_i=1, the granted bit of m_ack_o SHALL be 1 in the same cycle.
REQ-024 In BUSY with s_ack_i=1, m_rdata_o SHALL equal s_rdata_i in the same cycle.
REQ-025 In BUSY with s_ack_i=1, the next state SHALL be IDLE and grant SHALL clear.
REQ-026 In BUSY with s_error_i=1 and s_ack_i=0, the granted bit of m_error_o SHALL be 1 in the same cycle, and the block SHALL go to IDLE.
REQ-027 If s_ack_i and s_error_i are both 1, ack SHALL win: ack pulses and error is suppressed.
REQ-028 Timeout counter: 16 bits, cleared on entry to BUSY, incremented every BUSY cycle without ack or error.
REQ-029 When the timeout counter equals TIMEOUT-1 with no ack or error, the block SHALL pulse the granted m_error_o bit for 1 cycle.
REQ-030 In that timeout cycle, the block SHALL increment timeout_cnt_o, saturating at 255, and go to IDLE.
REQ-031 An ack or error arriving in the timeout cycle SHALL take priority over the timeout, and timeout_cnt_o SHALL NOT increment.
REQ-032 At least one IDLE cycle SHALL separate consecutive grants.
REQ-033 A master deasserting m_req_i while in BUSY is a protocol violation; the grant SHALL be held regardless.
REQ-034 m_ack_o and m_error_o bits of non-granted masters SHALL always be 0.
REQ-035 m_rdata_o SHALL be 0 when no ack is pulsed.
REQ-036 grant_o SHALL never have more than one bit set.

Reset
REQ-037 With rst=1 at an edge, the block SHALL set state=IDLE, grant=0, last_grant=NUM_MASTERS-1 (so master 0 wins first), timeout counter=0 and timeout_cnt_o=0.
REQ-038 Reset SHALL take effect in any state, including mid-transfer in BUSY; s_req_o SHALL be 0 in the cycle after the reset edge, and no ack or error is generated for the aborted transfer.
REQ-039 All outputs SHALL be 0 while in reset.

Structure
REQ-040 Package soc_arb_pkg SHALL hold the arb_state_t enum (IDLE, BUSY), the default TIMEOUT constant and the timeout-counter width.
REQ-041 The round-robin search SHALL be a combinational sub-module soc_rr_picker with inputs req and last_grant and output one-hot pick; it is reusable by the interrupt controller.
REQ-042 All state SHALL be in a single always_ff block; the muxes SHALL be always_comb.

Verification
REQ-043 Single master: m_req_i=01, addr 0x100, slave acks 3 cycles later -> s_req_o high in cycles 1..4, m_ack_o=01 in cycle 4, grant_o=00 in cycle 5.
REQ-044 Contention: m_req_i=11 held -> grants alternate 01,10,01 with one IDLE cycle between each; master 0 goes first after reset.
REQ-045 Timeout: TIMEOUT=8, slave silent -> m_error_o pulses for the granted master in the 8th BUSY cycle and timeout_cnt_o goes 0->1; 300 timeouts give timeout_cnt_o=255.
REQ-046 Simultaneous ack and error -> only the m_ack_o bit is set, rdata is passed through, and no error pulse occurs.
REQ-047 Ack in the timeout cycle -> ack is delivered and timeout_cnt_o is unchanged.
REQ-048 rst asserted in the 2nd BUSY cycle -> s_req_o=0 and grant_o=00 the next cycle, no ack or error, and the next grant goes to master 0.
